// File: rtl/alu_result_stage_pkg.sv
// alu_pkg: shared ALU types, control encodings and the hardwired-zero register index.
package alu_pkg;
  localparam int ALU_WIDTH = 64;
  localparam int ALU_REG_BITS = 5;
  localparam int XZR = 31;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;
  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_cntrl_e;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream ALU beat and downstream writeback handshake bundle.
interface alu_result_stage_if #(
  parameter int WIDTH = 64,
  parameter int REG_BITS = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_result;
  logic                in_negative;
  logic                in_zero;
  logic                in_overflow;
  logic                in_carry_out;
  logic [REG_BITS-1:0] in_rd;
  logic                in_reg_write;
  logic                in_set_flags;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_result;
  logic [REG_BITS-1:0] out_rd;
  logic                out_reg_write;
  modport master (
    output in_valid, in_result, in_negative, in_zero, in_overflow, in_carry_out,
           in_rd, in_reg_write, in_set_flags, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write
  );
  modport slave (
    input  in_valid, in_result, in_negative, in_zero, in_overflow, in_carry_out,
           in_rd, in_reg_write, in_set_flags, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_write
  );
endinterface

// File: rtl/alu_result_stage_skid.sv
// pipe_skid_buf: 2-entry valid/ready skid buffer with registered in_ready and sync flush.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         accept, pop, hold;
  assign accept = in_valid_i & ~skid_v_q;
  assign pop = main_v_q & out_ready_i;
  assign hold = main_v_q & ~pop;
  always_comb begin
    main_v_d = flush_i ? 1'b0 : hold | skid_v_q | accept;
    skid_v_d = flush_i ? 1'b0 : hold & (skid_v_q | accept);
    // payload regs only load on a real transfer, so a flushed beat never lands
    main_d = (hold | flush_i) ? main_q : skid_v_q ? skid_q : accept ? in_data_i : main_q;
    skid_d = (~flush_i & hold & accept) ? in_data_i : skid_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready_o = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o = main_q;
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU-to-writeback skid stage holding the architectural NZVC flags.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int REG_BITS = ALU_REG_BITS,
  parameter int ZERO_REG = XZR
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  alu_result_stage_if.slave bus,
  output logic flag_n_o,
  output logic flag_z_o,
  output logic flag_v_o,
  output logic flag_c_o
);
  localparam int W = WIDTH + REG_BITS + 1;
  logic [W-1:0] in_data, out_data;
  alu_flags_t   flags_q, flags_d;
  logic         in_ready, wr_en;
  assign wr_en = bus.in_reg_write & (bus.in_rd != REG_BITS'(ZERO_REG));
  assign in_data = {bus.in_result, bus.in_rd, wr_en};
  pipe_skid_buf #(.W(W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .in_valid_i (bus.in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (out_data)
  );
  assign bus.in_ready = in_ready;
  assign {bus.out_result, bus.out_rd, bus.out_reg_write} = out_data;
  always_comb begin
    flags_d = (bus.in_valid & in_ready & bus.in_set_flags & ~flush_i)
      ? '{n: bus.in_negative, z: bus.in_zero, v: bus.in_overflow, c: bus.in_carry_out}
      : flags_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else flags_q <= flags_d;
  end
  assign {flag_n_o, flag_z_o, flag_v_o, flag_c_o} = flags_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed scenario tasks with hand-computed expectations.
module tb_alu_result_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic fn, fz, fv, fc;
  int n_cmp = 0;
  int n_bad = 0;
  alu_result_stage_if #(.WIDTH(64), .REG_BITS(5)) bus ();
  alu_result_stage dut (
    .clk(clk), .reset(reset), .flush_i(flush), .bus(bus),
    .flag_n_o(fn), .flag_z_o(fz), .flag_v_o(fv), .flag_c_o(fc)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [4:0] rd,
                       input logic rw, input logic sf, input logic [3:0] nzvc);
    bus.in_valid = v;
    bus.in_result = r;
    bus.in_rd = rd;
    bus.in_reg_write = rw;
    bus.in_set_flags = sf;
    {bus.in_negative, bus.in_zero, bus.in_overflow, bus.in_carry_out} = nzvc;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_result !== 64'd0 || bus.out_rd !== 5'd0 || bus.out_reg_write !== 1'b0) begin
      n_bad++; $display("FAIL reset_payload got %h/%0d/%b want 0/0/0", bus.out_result, bus.out_rd, bus.out_reg_write); end
    n_cmp++; if ({fn, fz, fv, fc} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {fn, fz, fv, fc}); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 64'(i), 5'(i), 1, 0, 0);
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'(i) || bus.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_beat%0d got v=%b r=%0d rdy=%b want v=1 r=%0d rdy=1", i, bus.out_valid, bus.out_result, bus.in_ready, i); end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive(1, 64'hA, 5'd1, 1, 0, 0);
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_result !== 64'hA) begin
      n_bad++; $display("FAIL stall_first got rdy=%b r=%h want rdy=1 r=a", bus.in_ready, bus.out_result); end
    drive(1, 64'hB, 5'd2, 1, 0, 0);
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_result !== 64'hA || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_full got rdy=%b r=%h v=%b want rdy=0 r=a v=1", bus.in_ready, bus.out_result, bus.out_valid); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (bus.out_result !== 64'hA || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_hold got r=%h v=%b want r=a v=1", bus.out_result, bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_result !== 64'hB || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release got r=%h v=%b rdy=%b want r=b v=1 rdy=1", bus.out_result, bus.out_valid, bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flags();
    bus.out_ready = 1'b1;
    drive(1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 1, 1, 4'b1010);
    tick();
    n_cmp++; if ({fn, fz, fv, fc} !== 4'b1010) begin n_bad++; $display("FAIL flags_subs got %b want 1010", {fn, fz, fv, fc}); end
    drive(1, 64'd7, 5'd4, 1, 0, 4'b0101);
    tick();
    n_cmp++; if ({fn, fz, fv, fc} !== 4'b1010) begin n_bad++; $display("FAIL flags_add_hold got %b want 1010", {fn, fz, fv, fc}); end
    drive(0, 0, 0, 0, 1, 4'b0101);
    tick();
    n_cmp++; if ({fn, fz, fv, fc} !== 4'b1010) begin n_bad++; $display("FAIL flags_idle got %b want 1010", {fn, fz, fv, fc}); end
  endtask

  task automatic test_xzr();
    bus.out_ready = 1'b1;
    drive(1, 64'h55, 5'd31, 1, 0, 0);
    tick();
    n_cmp++; if (bus.out_reg_write !== 1'b0 || bus.out_result !== 64'h55 || bus.out_rd !== 5'd31 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL xzr_squash got we=%b r=%h rd=%0d v=%b want we=0 r=55 rd=31 v=1", bus.out_reg_write, bus.out_result, bus.out_rd, bus.out_valid); end
    drive(1, 64'h66, 5'd5, 1, 0, 0);
    tick();
    n_cmp++; if (bus.out_reg_write !== 1'b1 || bus.out_rd !== 5'd5 || bus.out_result !== 64'h66) begin
      n_bad++; $display("FAIL xzr_normal got we=%b rd=%0d r=%h want we=1 rd=5 r=66", bus.out_reg_write, bus.out_rd, bus.out_result); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1, 64'hC, 5'd6, 1, 0, 0);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'hC) begin
      n_bad++; $display("FAIL flush_pre got v=%b r=%h want v=1 r=c", bus.out_valid, bus.out_result); end
    drive(1, 64'hD, 5'd7, 1, 1, 4'b0101);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_empty got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    n_cmp++; if ({fn, fz, fv, fc} !== 4'b1010) begin n_bad++; $display("FAIL flush_flags got %b want 1010", {fn, fz, fv, fc}); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_beat%0d got v=%b r=%h want v=0", i, bus.out_valid, bus.out_result); end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1, 64'h11, 5'd8, 1, 1, 4'b1111);
    tick();
    drive(1, 64'h22, 5'd9, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.in_ready !== 1'b0 || {fn, fz, fv, fc} !== 4'b1111) begin
      n_bad++; $display("FAIL rstmid_full got rdy=%b flags=%b want rdy=0 flags=1111", bus.in_ready, {fn, fz, fv, fc}); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {fn, fz, fv, fc} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_async got v=%b rdy=%b flags=%b want v=0 rdy=1 flags=0000", bus.out_valid, bus.in_ready, {fn, fz, fv, fc}); end
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_beat%0d got v=%b r=%h want v=0", i, bus.out_valid, bus.out_result); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flags();
    test_xzr();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
